// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rc4_pkg;

    // Controller states; binary encoded in 5 bits
    typedef enum logic [4:0] {
        ST_IDLE      = 5'd0,
        ST_CLEAR     = 5'd1,
        ST_INIT      = 5'd2,
        ST_WAIT_INIT = 5'd3,
        ST_KSA       = 5'd4,
        ST_WAIT_KSA  = 5'd5,
        ST_DEC       = 5'd6,
        ST_WAIT_DEC  = 5'd7,
        ST_JUDGE     = 5'd8,
        ST_NEXT_KEY  = 5'd9,
        ST_FOUND     = 5'd10,
        ST_FAIL      = 5'd11
    } state_t;

    // Decrypt FSM memory_sel encodings
    localparam logic [1:0] MEM_SEL_IDLE = 2'd0;
    localparam logic [1:0] MEM_SEL_S    = 2'd1;
    localparam logic [1:0] MEM_SEL_ENC  = 2'd2;
    localparam logic [1:0] MEM_SEL_DEC  = 2'd3;

    // Accepted plaintext characters: lowercase letters and space
    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    localparam logic [5:0] CNT_MAX = 6'd63;

    function automatic logic is_printable(input logic [7:0] b);
        return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SP);
    endfunction

endpackage

// File: rtl/rc4_byte_checker.sv
// Judges decrypted output bytes: sticky bad flag plus saturating byte count.
// Latency: flag and count update on the edge that samples en.
// Backpressure: none; every enabled cycle is consumed.
module rc4_byte_checker
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] data,
    output logic       bad,
    output logic [5:0] count
);

    // Clear has priority; otherwise each enabled byte is counted and judged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad   <= 1'b0;
            count <= 6'd0;
        end else if (clear) begin
            bad   <= 1'b0;
            count <= 6'd0;
        end else if (en) begin
            if (!is_printable(data)) begin
                bad <= 1'b1;
            end
            // Saturate so an over-long message can never wrap back to MSG_LEN
            if (count != CNT_MAX) begin
                count <= count + 6'd1;
            end
        end
    end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Sequences init/KSA/decrypt per candidate key and stops on a printable message.
// Latency: 6 cycles per candidate plus the sub-FSM durations.
// Backpressure: waits on level finish flags; start ignored while busy.
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int                    KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0]  KEY_START = 24'h000000,
    parameter logic [KEY_WIDTH-1:0]  KEY_END   = 24'h3FFFFF,
    parameter int                    MSG_LEN   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 sub_clear,
    output logic                 init_start,
    output logic                 ksa_start,
    output logic                 dec_start,
    input  logic                 init_finish,
    input  logic                 ksa_finish,
    input  logic                 dec_finish,
    output logic [4:0]           iterations,
    input  logic                 dec_wen,
    input  logic [1:0]           dec_sel,
    input  logic [7:0]           dec_data,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 busy,
    output logic                 found,
    output logic                 fail
);

    state_t     state;
    logic       chk_clear;
    logic       chk_en;
    logic       chk_bad;
    logic [5:0] chk_count;

    assign iterations = 5'(MSG_LEN - 1);

    // Only decrypted-RAM writes during the decrypt phase are message bytes
    assign chk_clear = (state == ST_CLEAR);
    assign chk_en    = ((state == ST_DEC) || (state == ST_WAIT_DEC)) &&
                       dec_wen && (dec_sel == MEM_SEL_DEC);

    rc4_byte_checker u_checker (
        .clk   (clk),
        .reset (reset),
        .clear (chk_clear),
        .en    (chk_en),
        .data  (dec_data),
        .bad   (chk_bad),
        .count (chk_count)
    );

    // Controller FSM with registered pulses, status flags and key counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            key        <= '0;
            sub_clear  <= 1'b0;
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            dec_start  <= 1'b0;
            busy       <= 1'b0;
            found      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            sub_clear  <= 1'b0;
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            dec_start  <= 1'b0;
            case (state)
                ST_IDLE, ST_FOUND, ST_FAIL: begin
                    if (start) begin
                        key       <= KEY_START;
                        state     <= ST_CLEAR;
                        sub_clear <= 1'b1;
                        busy      <= 1'b1;
                        found     <= 1'b0;
                        fail      <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    state      <= ST_INIT;
                    init_start <= 1'b1;
                end
                ST_INIT:      state <= ST_WAIT_INIT;
                ST_WAIT_INIT: begin
                    if (init_finish) begin
                        state     <= ST_KSA;
                        ksa_start <= 1'b1;
                    end
                end
                ST_KSA:       state <= ST_WAIT_KSA;
                ST_WAIT_KSA: begin
                    if (ksa_finish) begin
                        state     <= ST_DEC;
                        dec_start <= 1'b1;
                    end
                end
                ST_DEC:       state <= ST_WAIT_DEC;
                ST_WAIT_DEC: begin
                    if (dec_finish) begin
                        state <= ST_JUDGE;
                    end
                end
                ST_JUDGE: begin
                    if (!chk_bad && (chk_count == 6'(MSG_LEN))) begin
                        state <= ST_FOUND;
                        found <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_NEXT_KEY;
                    end
                end
                ST_NEXT_KEY: begin
                    if (key == KEY_END) begin
                        state <= ST_FAIL;
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        key       <= key + KEY_WIDTH'(1);
                        state     <= ST_CLEAR;
                        sub_clear <= 1'b1;
                    end
                end
                default:      state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
module tb_rc4_key_search_ctrl;
    import rc4_pkg::*;

    localparam int SC_FIRST = 0, SC_BAD = 1, SC_RANGE = 2, SC_SHORT = 3, SC_B60 = 4;
    localparam int SC_B7A = 5, SC_B20 = 6, SC_LONG = 7, SC_SAT = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] start_r = 2'b00;

    // DUT outputs (instance 0: keys 0..3, instance 1: keys 3..5)
    logic sc0, is0, ks0, ds0, busy0, found0, fail0;
    logic sc1, is1, ks1, ds1, busy1, found1, fail1;
    logic [4:0]  it0, it1;
    logic [23:0] key0, key1;

    // Sub-FSM model outputs
    logic [1:0] init_fin, ksa_fin, dec_fin, dec_wen;
    logic [1:0] dec_sel_m  [2];
    logic [7:0] dec_data_m [2];

    logic [1:0] sc_v, is_v, ks_v, ds_v;
    assign sc_v = {sc1, sc0};
    assign is_v = {is1, is0};
    assign ks_v = {ks1, ks0};
    assign ds_v = {ds1, ds0};

    int scen = SC_FIRST;
    int ksa_delay = 1;
    int nchk = 0;
    int nfail = 0;

    // Monotonic pulse counters and sub_clear->init_start spacing check
    int cyc = 0;
    int n_sc [2] = '{0, 0};
    int n_is [2] = '{0, 0};
    int n_ks [2] = '{0, 0};
    int n_ds [2] = '{0, 0};
    int last_sc [2] = '{-10, -10};
    int seq_err = 0;

    always #5 clk = ~clk;

    rc4_key_search_ctrl #(.KEY_WIDTH(24), .KEY_START(24'd0), .KEY_END(24'd3), .MSG_LEN(32)) dut0 (
        .clk(clk), .reset(reset), .start(start_r[0]), .sub_clear(sc0), .init_start(is0),
        .ksa_start(ks0), .dec_start(ds0), .init_finish(init_fin[0]), .ksa_finish(ksa_fin[0]),
        .dec_finish(dec_fin[0]), .iterations(it0), .dec_wen(dec_wen[0]), .dec_sel(dec_sel_m[0]),
        .dec_data(dec_data_m[0]), .key(key0), .busy(busy0), .found(found0), .fail(fail0));

    rc4_key_search_ctrl #(.KEY_WIDTH(24), .KEY_START(24'd3), .KEY_END(24'd5), .MSG_LEN(32)) dut1 (
        .clk(clk), .reset(reset), .start(start_r[1]), .sub_clear(sc1), .init_start(is1),
        .ksa_start(ks1), .dec_start(ds1), .init_finish(init_fin[1]), .ksa_finish(ksa_fin[1]),
        .dec_finish(dec_fin[1]), .iterations(it1), .dec_wen(dec_wen[1]), .dec_sel(dec_sel_m[1]),
        .dec_data(dec_data_m[1]), .key(key1), .busy(busy1), .found(found1), .fail(fail1));

    function automatic logic [23:0] key_of(input int i);
        return (i == 0) ? key0 : key1;
    endfunction

    function automatic int msg_len(input logic [23:0] k);
        case (scen)
            SC_SHORT: return (k == 24'd0) ? 31 : 32;
            SC_LONG:  return (k == 24'd0) ? 33 : 32;
            SC_SAT:   return (k == 24'd0) ? 96 : 32;
            default:  return 32;
        endcase
    endfunction

    function automatic logic [7:0] msg_byte(input logic [23:0] k, input int n);
        case (scen)
            SC_BAD:   return (k == 24'd0) ? ((n == 5) ? 8'h41 : 8'h61) : 8'h20;
            SC_RANGE: return (n == 7) ? 8'h7B : 8'h61;
            SC_SHORT: return (k == 24'd0) ? 8'h62 : 8'h79;
            SC_B60:   return ((k == 24'd0) && (n == 3)) ? 8'h60 : 8'h61;
            SC_B7A:   return 8'h7A;
            SC_B20:   return 8'h20;
            default:  return 8'h61;
        endcase
    endfunction

    // Behavioural init/KSA/decrypt FSMs; decrypt interleaves S-writes with output bytes
    logic [1:0] running, phase;
    int idx [2];
    int ksa_cnt [2];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            init_fin <= '0; ksa_fin <= '0; dec_fin <= '0; dec_wen <= '0;
            running <= '0; phase <= '0;
            for (int i = 0; i < 2; i++) begin
                dec_sel_m[i] <= MEM_SEL_IDLE; dec_data_m[i] <= 8'h00;
                idx[i] <= 0; ksa_cnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                dec_wen[i] <= 1'b0; dec_sel_m[i] <= MEM_SEL_IDLE; dec_data_m[i] <= 8'h00;
                if (sc_v[i]) begin
                    init_fin[i] <= 1'b0; ksa_fin[i] <= 1'b0; dec_fin[i] <= 1'b0;
                    running[i] <= 1'b0; ksa_cnt[i] <= 0;
                end else begin
                    if (is_v[i]) begin
                        init_fin[i] <= 1'b1;
                        // stray decrypted-RAM write outside the decrypt phase
                        dec_wen[i] <= 1'b1; dec_sel_m[i] <= MEM_SEL_DEC; dec_data_m[i] <= 8'h00;
                    end
                    if (ks_v[i]) ksa_cnt[i] <= ksa_delay;
                    else if (ksa_cnt[i] == 1) begin ksa_fin[i] <= 1'b1; ksa_cnt[i] <= 0; end
                    else if (ksa_cnt[i] > 1) ksa_cnt[i] <= ksa_cnt[i] - 1;
                    if (ds_v[i]) begin
                        running[i] <= 1'b1; idx[i] <= 0; phase[i] <= 1'b0;
                    end else if (running[i]) begin
                        dec_wen[i] <= 1'b1;
                        if (phase[i]) begin
                            dec_sel_m[i] <= MEM_SEL_S; dec_data_m[i] <= 8'h00; phase[i] <= 1'b0;
                        end else begin
                            dec_sel_m[i] <= MEM_SEL_DEC;
                            dec_data_m[i] <= msg_byte(key_of(i), idx[i]);
                            phase[i] <= 1'b1;
                            idx[i] <= idx[i] + 1;
                            if (idx[i] == msg_len(key_of(i)) - 1) begin
                                dec_fin[i] <= 1'b1; running[i] <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            n_sc[i] <= n_sc[i] + int'(sc_v[i]);
            n_is[i] <= n_is[i] + int'(is_v[i]);
            n_ks[i] <= n_ks[i] + int'(ks_v[i]);
            n_ds[i] <= n_ds[i] + int'(ds_v[i]);
            if (sc_v[i]) last_sc[i] <= cyc;
            if (is_v[i] && (last_sc[i] != cyc - 1)) seq_err <= seq_err + 1;
        end
    end

    task automatic pulse_start(input int i);
        @(negedge clk); start_r[i] = 1'b1;
        @(negedge clk); start_r[i] = 1'b0;
    endtask

    task automatic wait_term(input int i, input int maxc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < maxc && !ok; c++) begin
            @(negedge clk);
            ok = (i == 0) ? (found0 | fail0) : (found1 | fail1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nchk++; if ({sc0, is0, ks0, ds0} !== 4'b0000) begin nfail++; $display("FAIL reset_pulses: got %b want 0000", {sc0, is0, ks0, ds0}); end
        nchk++; if ({busy0, found0, fail0} !== 3'b000) begin nfail++; $display("FAIL reset_status: got %b want 000", {busy0, found0, fail0}); end
        nchk++; if (key0 !== 24'd0) begin nfail++; $display("FAIL reset_key: got %0h want 0", key0); end
        nchk++; if (it0 !== 5'd31) begin nfail++; $display("FAIL iterations0: got %0d want 31", it0); end
        nchk++; if (it1 !== 5'd31) begin nfail++; $display("FAIL iterations1: got %0d want 31", it1); end
        reset = 1'b0;
    endtask

    task automatic test_first_key();
        int b_sc, b_is, b_ks, b_ds;
        bit ok;
        scen = SC_FIRST;
        b_sc = n_sc[0]; b_is = n_is[0]; b_ks = n_ks[0]; b_ds = n_ds[0];
        pulse_start(0);
        nchk++; if (busy0 !== 1'b1) begin nfail++; $display("FAIL first_busy_rise: got %b want 1", busy0); end
        wait_term(0, 2000, ok);
        nchk++; if (!ok) begin nfail++; $display("FAIL first_timeout: got no terminal state want found"); end
        nchk++; if ({found0, fail0, busy0} !== 3'b100) begin nfail++; $display("FAIL first_status: got %b want 100", {found0, fail0, busy0}); end
        nchk++; if (key0 !== 24'd0) begin nfail++; $display("FAIL first_key: got %0h want 0", key0); end
        nchk++; if ((n_sc[0] - b_sc) != 1 || (n_is[0] - b_is) != 1 || (n_ks[0] - b_ks) != 1 || (n_ds[0] - b_ds) != 1) begin
            nfail++; $display("FAIL first_pulses: got %0d %0d %0d %0d want 1 1 1 1", n_sc[0] - b_sc, n_is[0] - b_is, n_ks[0] - b_ks, n_ds[0] - b_ds);
        end
    endtask

    // Runs one search on instance 0 and checks found with the expected key and candidate count
    task automatic run_found(input int s, input logic [23:0] exp_key, input int exp_cand, input string name);
        int b_sc;
        bit ok;
        scen = s;
        b_sc = n_sc[0];
        pulse_start(0);
        wait_term(0, 3000, ok);
        nchk++; if (!ok || found0 !== 1'b1 || fail0 !== 1'b0) begin nfail++; $display("FAIL %s_found: got found=%b fail=%b want found=1 fail=0", name, found0, fail0); end
        nchk++; if (key0 !== exp_key) begin nfail++; $display("FAIL %s_key: got %0h want %0h", name, key0, exp_key); end
        nchk++; if ((n_sc[0] - b_sc) != exp_cand) begin nfail++; $display("FAIL %s_clears: got %0d want %0d", name, n_sc[0] - b_sc, exp_cand); end
    endtask

    task automatic test_bad_byte();
        run_found(SC_BAD, 24'd1, 2, "bad_byte");
    endtask

    task automatic test_short_and_long();
        run_found(SC_SHORT, 24'd1, 2, "short_msg");
        run_found(SC_LONG, 24'd1, 2, "long_msg");
        run_found(SC_SAT, 24'd1, 2, "saturate");
    endtask

    task automatic test_boundary_bytes();
        run_found(SC_B60, 24'd1, 2, "byte_60");
        run_found(SC_B7A, 24'd0, 1, "byte_7a");
        run_found(SC_B20, 24'd0, 1, "byte_20");
    endtask

    task automatic test_range_exhausted();
        int b_sc, b_ds;
        bit ok;
        scen = SC_RANGE;
        b_sc = n_sc[1]; b_ds = n_ds[1];
        pulse_start(1);
        nchk++; if (key1 !== 24'd3) begin nfail++; $display("FAIL range_start_key: got %0h want 3", key1); end
        wait_term(1, 3000, ok);
        nchk++; if (!ok || {fail1, found1, busy1} !== 3'b100) begin nfail++; $display("FAIL range_status: got fail/found/busy=%b want 100", {fail1, found1, busy1}); end
        nchk++; if (key1 !== 24'd5) begin nfail++; $display("FAIL range_key: got %0h want 5", key1); end
        nchk++; if ((n_ds[1] - b_ds) != 3 || (n_sc[1] - b_sc) != 3) begin nfail++; $display("FAIL range_pulses: got dec=%0d clr=%0d want 3 3", n_ds[1] - b_ds, n_sc[1] - b_sc); end
        repeat (3) @(negedge clk);
        nchk++; if (fail1 !== 1'b1 || key1 !== 24'd5) begin nfail++; $display("FAIL range_hold: got fail=%b key=%0h want 1 5", fail1, key1); end
    endtask

    task automatic test_reset_restart();
        int b_ks, b_sc;
        bit ok;
        scen = SC_BAD; ksa_delay = 20;
        b_ks = n_ks[0];
        pulse_start(0);
        ok = 1'b0;
        for (int c = 0; c < 500 && !ok; c++) begin @(negedge clk); ok = (n_ks[0] - b_ks) >= 2; end
        nchk++; if (!ok) begin nfail++; $display("FAIL rst_reach_wait_ksa: got %0d ksa pulses want 2", n_ks[0] - b_ks); end
        @(negedge clk);
        nchk++; if (busy0 !== 1'b1 || key0 !== 24'd1) begin nfail++; $display("FAIL rst_pre: got busy=%b key=%0h want 1 1", busy0, key0); end
        #1 reset = 1'b1;
        #1;
        nchk++; if ({busy0, found0, fail0, fail1} !== 4'b0000) begin nfail++; $display("FAIL rst_async_status: got %b want 0000", {busy0, found0, fail0, fail1}); end
        nchk++; if (key0 !== 24'd0 || key1 !== 24'd0) begin nfail++; $display("FAIL rst_async_key: got %0h %0h want 0 0", key0, key1); end
        nchk++; if ({sc0, is0, ks0, ds0} !== 4'b0000) begin nfail++; $display("FAIL rst_async_pulses: got %b want 0000", {sc0, is0, ks0, ds0}); end
        @(negedge clk); reset = 1'b0; ksa_delay = 1;
        // start while busy must not restart the search
        b_sc = n_sc[0];
        pulse_start(0);
        repeat (3) @(negedge clk);
        pulse_start(0);
        repeat (100) @(negedge clk);
        pulse_start(0);
        wait_term(0, 3000, ok);
        nchk++; if (!ok || found0 !== 1'b1 || key0 !== 24'd1) begin nfail++; $display("FAIL busy_start_result: got found=%b key=%0h want 1 1", found0, key0); end
        nchk++; if ((n_sc[0] - b_sc) != 2) begin nfail++; $display("FAIL busy_start_ignored: got %0d clears want 2", n_sc[0] - b_sc); end
        // start from FOUND restarts at KEY_START
        b_sc = n_sc[0];
        pulse_start(0);
        nchk++; if (key0 !== 24'd0 || busy0 !== 1'b1 || found0 !== 1'b0) begin nfail++; $display("FAIL restart_found: got key=%0h busy=%b found=%b want 0 1 0", key0, busy0, found0); end
        wait_term(0, 3000, ok);
        nchk++; if (!ok || found0 !== 1'b1 || key0 !== 24'd1 || (n_sc[0] - b_sc) != 2) begin
            nfail++; $display("FAIL restart_result: got found=%b key=%0h clears=%0d want 1 1 2", found0, key0, n_sc[0] - b_sc);
        end
        nchk++; if (seq_err != 0) begin nfail++; $display("FAIL clear_to_init_spacing: got %0d violations want 0", seq_err); end
    endtask

    initial begin
        test_reset();
        test_first_key();
        test_bad_byte();
        test_range_exhausted();
        test_short_and_long();
        test_boundary_bytes();
        test_reset_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/rc4_key_search_ctrl.md
# rc4_key_search_ctrl

Top-level sequencer for the RC4 cracking datapath. Runs S-array init, key schedule and message decrypt once per candidate key, checks every decrypted byte on the fly, and advances the key until a fully printable message is produced or the key range is exhausted. Sits above the init, KSA and decrypt FSMs and drives their start, clear and iteration inputs.

## Interface
- KEY_WIDTH, 24, candidate key width.
- KEY_START, 24'h000000, first key tried.
- KEY_END, 24'h3FFFFF, last key tried, inclusive; must be ≥ KEY_START.
- MSG_LEN, 32, decrypted message length in bytes, 1..32.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- start  in  1  one-cycle request to begin a search; honoured only in IDLE, FOUND or FAIL.
- sub_clear  out  1  one-cycle reset pulse to the init, KSA and decrypt FSMs; reset value 0.
- init_start, ksa_start, dec_start  out  1 each  one-cycle start pulses; reset value 0.
- init_finish, ksa_finish, dec_finish  in  1 each  level-sensitive done flags from the sub-FSMs.
- iterations  out  5  constant MSG_LEN-1, wired to the decrypt FSM.
- dec_wen  in  1  decrypt write-enable monitor.
- dec_sel  in  2  decrypt memory_sel monitor; value 3 marks a write to decrypted output.
- dec_data  in  8  decrypt write data monitor.
- key  out  KEY_WIDTH  current candidate key; reset value 0.
- busy  out  1  high from leaving IDLE/FOUND/FAIL until entering FOUND or FAIL; reset value 0.
- found  out  1  level, high in FOUND; reset value 0.
- fail  out  1  level, high in FAIL; reset value 0.

## Operation
- States: IDLE, CLEAR, INIT, WAIT_INIT, KSA, WAIT_KSA, DEC, WAIT_DEC, JUDGE, NEXT_KEY, FOUND, FAIL.
- IDLE/FOUND/FAIL + start: key←KEY_START, then go to CLEAR. FOUND and FAIL otherwise hold; key keeps its last value.
- CLEAR: sub_clear=1. Clear bad flag and byte count. Go to INIT.
- INIT: init_start=1, go to WAIT_INIT. WAIT_INIT: hold until init_finish=1, then go to KSA.
- KSA / WAIT_KSA and DEC / WAIT_DEC behave the same way, using their own start and finish signals.
- Byte check: active during DEC and WAIT_DEC.
  - Each cycle with dec_wen=1 and dec_sel=3 is one output byte: count increments, saturating at 63.
  - The byte is valid if it is in 8'h61..8'h7A or equals 8'h20. Any other value sets bad, which is sticky until CLEAR.
  - An output write in the same cycle that dec_finish is sampled is still counted and checked.
- JUDGE: pass if bad=0 and count==MSG_LEN, then go to FOUND. Otherwise go to NEXT_KEY.
- NEXT_KEY: if key==KEY_END go to FAIL (key not incremented, no wrap). Otherwise key←key+1 and go to CLEAR.
- Writes with dec_sel≠3, and writes outside DEC/WAIT_DEC, are ignored.
- Reset mid-operation forces IDLE and all outputs to reset values on the same edge. No sub_clear pulse is issued; the sub-FSMs share the global reset.
- start outside IDLE/FOUND/FAIL is ignored, with no queuing.

## Timing
- Every start and clear output is a single-cycle registered pulse driven from the state register.
- sub_clear is issued exactly one cycle before init_start, so the sub-FSMs are in idle when sampled.
- Finish flags are sampled the cycle after the matching start at the earliest. A finish already high when WAIT_* is entered is accepted immediately; sub_clear guarantees it was deasserted.
- Fixed overhead per candidate: CLEAR + INIT + KSA + DEC + JUDGE + NEXT_KEY = 6 cycles, plus the sub-FSM durations.
- busy rises the cycle after start is accepted. found or fail rises on entry to the terminal state, and busy falls on that same edge.

## Structure
- Shared package rc4_pkg holds:
  - the state enum (5-bit, one-hot not required);
  - the MEM_SEL_* constants (0 idle, 1 S, 2 encrypted ROM, 3 decrypted RAM);
  - the printable-range constants CHAR_LO=8'h61, CHAR_HI=8'h7A, CHAR_SP=8'h20.
- Sub-module rc4_byte_checker holds the valid-byte comparator, the sticky bad flag and the 6-bit saturating counter.
  - Ports: clk, reset, clear, en, data, bad, count.
- Controller FSM and key counter live in the top module.

## Test plan
- Key found on the first candidate: start=1 with KEY_START=0; model emits 32 bytes of 8'h61.
  - Required: found=1, key=0, exactly one sub_clear/init_start/ksa_start/dec_start each.
- Bad byte: key 0 emits 8'h41 at byte 5; key 1 emits all 8'h20.
  - Required: found=1 with key=1, two sub_clear pulses.
- Range exhausted: KEY_START=3, KEY_END=5, every candidate emits one 8'h7B.
  - Required: fail=1, key=5, busy=0, three dec_start pulses.
- Short message: decrypt emits 31 valid bytes, then dec_finish.
  - Required: judged bad, key advances.
- Boundary bytes: bytes 8'h60, 8'h7A, 8'h20 each tested in isolation.
  - Required: 8'h60 rejects; 8'h7A and 8'h20 accept.
- Reset and restart: reset asserted during WAIT_KSA.
  - Required: outputs reset asynchronously; start is ignored while busy; start in FOUND restarts at KEY_START.
